// File: rtl/uart_pkg.sv
// uart_pkg: shared UART clocking constants and the phase-increment helper
package uart_pkg;

    localparam longint unsigned CLK_FREQ_HZ = 64'd25_000_000;

    // round-half-up of baud*os*2^acc_w/clk_freq, usable in constant expressions
    function automatic logic [31:0] calc_inc(
        input longint unsigned clk_freq,
        input longint unsigned baud,
        input longint unsigned os,
        input longint unsigned acc_w
    );
        return 32'(((baud * os << acc_w) + clk_freq / 64'd2) / clk_freq);
    endfunction

    // standard rates, x16 oversample, 24-bit accumulator, 25 MHz clock
    localparam logic [31:0] INC_9600   = calc_inc(CLK_FREQ_HZ, 64'd9600,   64'd16, 64'd24);
    localparam logic [31:0] INC_19200  = calc_inc(CLK_FREQ_HZ, 64'd19200,  64'd16, 64'd24);
    localparam logic [31:0] INC_57600  = calc_inc(CLK_FREQ_HZ, 64'd57600,  64'd16, 64'd24);
    localparam logic [31:0] INC_115200 = calc_inc(CLK_FREQ_HZ, 64'd115200, 64'd16, 64'd24);

endpackage

// File: rtl/baud_phase_acc.sv
// baud_phase_acc: fractional phase accumulator producing the oversample tick
//   clk, rst_n : clock, async active-low reset
//   step       : advance the accumulator by inc_q this edge
//   clr        : zero the accumulator (wins over step)
//   ld         : load cfg_inc into inc_q
//   cfg_inc    : new phase increment
//   carry      : combinational wrap indication for this edge (step qualified)
//   os_tick    : registered carry
//   rate_valid : inc_q is nonzero
module baud_phase_acc
    import uart_pkg::*;
#(
    parameter int          ACC_W       = 24,
    parameter int unsigned DEFAULT_INC = INC_115200
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    input  logic             clr,
    input  logic             ld,
    input  logic [ACC_W-1:0] cfg_inc,
    output logic             carry,
    output logic             os_tick,
    output logic             rate_valid
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc_q;
    logic [ACC_W:0]   sum;

    assign sum        = {1'b0, acc} + {1'b0, inc_q};
    assign carry      = step & sum[ACC_W];
    assign rate_valid = inc_q != '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            inc_q   <= ACC_W'(DEFAULT_INC);
            os_tick <= 1'b0;
        end else begin
            if (ld)
                inc_q <= cfg_inc;
            acc     <= clr ? '0 : step ? sum[ACC_W-1:0] : acc;
            os_tick <= carry;
        end
    end

endmodule

// File: rtl/baud_gen_frac.sv
// baud_gen_frac: fractional UART baud generator with oversample and bit ticks
//   clk, rst_n : clock, async active-low reset
//   en         : run enable (freeze when low)
//   cfg_we     : strobe loading cfg_inc, clears phase
//   cfg_inc    : phase increment
//   sync       : phase restart strobe (RX start edge)
//   os_tick    : registered oversample tick
//   baud_tick  : registered bit tick, always coincident with os_tick
//   os_phase   : oversample counter
//   rate_valid : active increment nonzero
module baud_gen_frac
    import uart_pkg::*;
#(
    parameter int          ACC_W       = 24,
    parameter int          OVERSAMPLE  = 16,
    parameter int unsigned DEFAULT_INC = INC_115200,
    parameter int          SYNC_MID    = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          cfg_we,
    input  logic [ACC_W-1:0]              cfg_inc,
    input  logic                          sync,
    output logic                          os_tick,
    output logic                          baud_tick,
    output logic [$clog2(OVERSAMPLE)-1:0] os_phase,
    output logic                          rate_valid
);

    localparam int PH_W = $clog2(OVERSAMPLE);
    localparam logic [PH_W-1:0] SYNC_CNT = SYNC_MID != 0 ? PH_W'(OVERSAMPLE / 2) : '0;
    localparam logic [PH_W-1:0] LAST_CNT = PH_W'(OVERSAMPLE - 1);

    logic            clr;
    logic            step;
    logic            carry;
    logic            last;
    logic [PH_W-1:0] os_cnt;

    // cfg_we outranks sync; either one suppresses accumulation this edge
    assign clr      = cfg_we | sync;
    assign step     = en & ~clr;
    assign last     = os_cnt == LAST_CNT;
    assign os_phase = os_cnt;

    baud_phase_acc #(
        .ACC_W       (ACC_W),
        .DEFAULT_INC (DEFAULT_INC)
    ) u_acc (
        .clk        (clk),
        .rst_n      (rst_n),
        .step       (step),
        .clr        (clr),
        .ld         (cfg_we),
        .cfg_inc    (cfg_inc),
        .carry      (carry),
        .os_tick    (os_tick),
        .rate_valid (rate_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            os_cnt    <= '0;
            baud_tick <= 1'b0;
        end else begin
            os_cnt    <= cfg_we ? '0 : sync ? SYNC_CNT : carry ? (last ? '0 : os_cnt + 1'b1) : os_cnt;
            baud_tick <= carry & last;
        end
    end

endmodule

// File: tb/tb_baud_gen_frac.sv
// tb_baud_gen_frac: directed self-checking bench for baud_gen_frac
module tb_baud_gen_frac;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       cfg_we = 1'b0;
    logic [7:0] cfg_inc = 8'd0;
    logic       sync = 1'b0;

    logic       m_os, m_baud, m_rv;
    logic [1:0] m_ph;
    logic       n_os, n_baud, n_rv;
    logic [1:0] n_ph;
    logic       d_os, d_baud, d_rv;
    logic [3:0] d_ph;

    int checks = 0;
    int errors = 0;

    always #20 clk = ~clk;

    baud_gen_frac #(.ACC_W(8), .OVERSAMPLE(4), .DEFAULT_INC(100), .SYNC_MID(1)) u_m (
        .clk(clk), .rst_n(rst_n), .en(en), .cfg_we(cfg_we), .cfg_inc(cfg_inc), .sync(sync),
        .os_tick(m_os), .baud_tick(m_baud), .os_phase(m_ph), .rate_valid(m_rv));

    baud_gen_frac #(.ACC_W(8), .OVERSAMPLE(4), .DEFAULT_INC(100), .SYNC_MID(0)) u_n (
        .clk(clk), .rst_n(rst_n), .en(en), .cfg_we(cfg_we), .cfg_inc(cfg_inc), .sync(sync),
        .os_tick(n_os), .baud_tick(n_baud), .os_phase(n_ph), .rate_valid(n_rv));

    baud_gen_frac u_d (
        .clk(clk), .rst_n(rst_n), .en(1'b1), .cfg_we(1'b0), .cfg_inc(24'd0), .sync(1'b0),
        .os_tick(d_os), .baud_tick(d_baud), .os_phase(d_ph), .rate_valid(d_rv));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load(input logic [7:0] v);
        cfg_inc = v;
        cfg_we = 1'b1;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        en = 1'b1;
        rst_n = 1'b0;
        repeat (5) step();
        checks++;
        if ({m_os, m_baud, m_ph, m_rv} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_small got os=%0b baud=%0b ph=%0d rv=%0b want 0 0 0 1", m_os, m_baud, m_ph, m_rv);
        end
        checks++;
        if ({n_os, n_baud, n_ph, n_rv} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_nomid got os=%0b baud=%0b ph=%0d rv=%0b want 0 0 0 1", n_os, n_baud, n_ph, n_rv);
        end
        checks++;
        if ({d_os, d_baud, d_ph, d_rv} !== 7'b0000001) begin
            errors++;
            $display("FAIL reset_default got os=%0b baud=%0b ph=%0d rv=%0b want 0 0 0 1", d_os, d_baud, d_ph, d_rv);
        end
        release_reset();
    endtask

    task automatic test_fractional();
        int n_os = 0;
        int n_b = 0;
        int last_os = -1;
        int last_b = -1;
        rst_n = 1'b0;
        repeat (2) step();
        release_reset();
        for (int i = 1; i <= 25000; i++) begin
            step();
            if (d_os) begin
                if (last_os >= 0) begin
                    checks++;
                    if (i - last_os != 13 && i - last_os != 14) begin
                        errors++;
                        $display("FAIL frac_os_gap at cycle %0d got %0d want 13..14", i, i - last_os);
                    end
                end
                last_os = i;
                n_os++;
            end
            if (d_baud) begin
                checks++;
                if (!d_os) begin
                    errors++;
                    $display("FAIL frac_baud_coincide at cycle %0d got os=0 want 1", i);
                end
                if (last_b >= 0) begin
                    checks++;
                    if (i - last_b < 216 || i - last_b > 218) begin
                        errors++;
                        $display("FAIL frac_baud_gap at cycle %0d got %0d want 216..218", i, i - last_b);
                    end
                end
                last_b = i;
                n_b++;
            end
        end
        checks++;
        if (n_os != 1843 && n_os != 1844) begin
            errors++;
            $display("FAIL frac_os_count got %0d want 1843..1844", n_os);
        end
        checks++;
        if (n_b != 115 && n_b != 116) begin
            errors++;
            $display("FAIL frac_baud_count got %0d want 115..116", n_b);
        end
    endtask

    task automatic test_exact_divide();
        en = 1'b1;
        load(8'd64);
        checks++;
        if ({m_os, m_baud, m_ph} !== 4'b0000) begin
            errors++;
            $display("FAIL exact_load got os=%0b baud=%0b ph=%0d want 0 0 0", m_os, m_baud, m_ph);
        end
        for (int i = 1; i <= 32; i++) begin
            step();
            checks++;
            if ({m_os, m_baud, m_ph} !== {i % 4 == 0, i % 16 == 0, 2'((i / 4) % 4)}) begin
                errors++;
                $display("FAIL exact_edge%0d got os=%0b baud=%0b ph=%0d want %0b %0b %0d",
                         i, m_os, m_baud, m_ph, i % 4 == 0, i % 16 == 0, (i / 4) % 4);
            end
        end
    endtask

    task automatic test_sync();
        en = 1'b1;
        load(8'd64);
        repeat (6) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        checks++;
        if ({m_ph, n_ph, m_os, n_os} !== {2'd2, 2'd0, 2'b00}) begin
            errors++;
            $display("FAIL sync_load got mid_ph=%0d full_ph=%0d os=%0b%0b want 2 0 00", m_ph, n_ph, m_os, n_os);
        end
        for (int i = 1; i <= 16; i++) begin
            step();
            checks++;
            if ({m_os, m_baud, n_os, n_baud} !== {i % 4 == 0, i == 8, i % 4 == 0, i == 16}) begin
                errors++;
                $display("FAIL sync_edge%0d got mid os=%0b baud=%0b full os=%0b baud=%0b want %0b %0b %0b %0b",
                         i, m_os, m_baud, n_os, n_baud, i % 4 == 0, i == 8, i % 4 == 0, i == 16);
            end
        end
    endtask

    task automatic test_enable();
        int cnt = 0;
        repeat (2) step();
        en = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            checks++;
            if ({m_os, m_baud, m_ph} !== 4'b0010) begin
                errors++;
                $display("FAIL freeze_cycle%0d got os=%0b baud=%0b ph=%0d want 0 0 2", i, m_os, m_baud, m_ph);
            end
        end
        en = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            step();
            checks++;
            if ({m_os, m_baud} !== {j % 4 == 2, j == 6}) begin
                errors++;
                $display("FAIL resume_edge%0d got os=%0b baud=%0b want %0b %0b", j, m_os, m_baud, j % 4 == 2, j == 6);
            end
        end
        cfg_inc = 8'd64;
        cfg_we = 1'b1;
        sync = 1'b1;
        step();
        cfg_we = 1'b0;
        sync = 1'b0;
        checks++;
        if ({m_ph, n_ph} !== 4'b0000) begin
            errors++;
            $display("FAIL prio_phase got mid_ph=%0d full_ph=%0d want 0 0", m_ph, n_ph);
        end
        for (int j = 1; j <= 4; j++) begin
            step();
            checks++;
            if (m_os !== (j == 4)) begin
                errors++;
                $display("FAIL prio_edge%0d got os=%0b want %0b", j, m_os, j == 4);
            end
        end
        load(8'd0);
        checks++;
        if (m_rv !== 1'b0) begin
            errors++;
            $display("FAIL zero_rate_valid got %0b want 0", m_rv);
        end
        for (int j = 1; j <= 20; j++) begin
            step();
            if (m_os || m_baud) cnt++;
        end
        checks++;
        if (cnt != 0) begin
            errors++;
            $display("FAIL zero_ticks got %0d want 0", cnt);
        end
    endtask

    task automatic test_async_reset();
        en = 1'b1;
        load(8'd64);
        repeat (4) step();
        checks++;
        if ({m_os, m_ph} !== 3'b101) begin
            errors++;
            $display("FAIL areset_pre got os=%0b ph=%0d want 1 1", m_os, m_ph);
        end
        #5;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({m_os, m_baud, m_ph} !== 4'b0000) begin
            errors++;
            $display("FAIL areset_clear got os=%0b baud=%0b ph=%0d want 0 0 0", m_os, m_baud, m_ph);
        end
        repeat (2) step();
        release_reset();
        for (int i = 1; i <= 6; i++) begin
            step();
            checks++;
            if ({m_os, m_rv} !== {i == 3 || i == 6, 1'b1}) begin
                errors++;
                $display("FAIL areset_edge%0d got os=%0b rv=%0b want %0b 1", i, m_os, m_rv, i == 3 || i == 6);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fractional();
        test_exact_divide();
        test_sync();
        test_enable();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
